// File: rtl/vga_timing_pkg.sv
// Default VGA timing constants (640x480 @ 25.2 MHz class) shared by
// the timing generator and its axis counters.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 64;
    localparam int DEF_H_BP     = 120;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 16;
    localparam int DEF_CW       = 10;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                               + DEF_H_SYNC + DEF_H_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one scan axis; load parks it on the last
// position so the next enabled edge lands on zero.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = DEF_H_TOTAL,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          en,
    input  logic          load,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic at_last;

    assign at_last = (count == LAST);
    assign wrap    = en & at_last;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= LAST;
        end else if (en) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync pulses, blanking and
// frame counter, all decoded combinationally from the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE  = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic h_wrap;
    logic v_wrap;
    logic armed;
    logic h_in_sync;
    logic v_in_sync;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .CW    (CW)
    ) u_h (
        .clk   (clk),
        .en    (pix_en),
        .load  (Reset),
        .count (h_count),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .CW    (CW)
    ) u_v (
        .clk   (clk),
        .en    (h_wrap),
        .load  (Reset),
        .count (v_count),
        .wrap  (v_wrap)
    );

    // The wrap out of reset is not a completed frame, so it is not counted.
    always_ff @(posedge clk) begin
        if (Reset) begin
            armed     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (pix_en) begin
                armed <= 1'b1;
            end
            if (v_wrap && armed) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign h_in_sync = (h_count >= H_SS) && (h_count < H_SE);
    assign v_in_sync = (v_count >= V_SS) && (v_count < V_SE);

    assign h_sync      = h_in_sync ? H_POL : ~H_POL;
    assign v_sync      = v_in_sync ? V_POL : ~V_POL;
    assign active      = (h_count < H_ACT) && (v_count < V_ACT);
    assign line_start  = (h_count == '0);
    assign frame_start = (h_count == '0) && (v_count == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a tiny raster for
// frame-level behaviour, and an 800x600 positive-sync instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic Reset;
    logic pix_en;

    always #5 clk = ~clk;

    logic [9:0]  d_h, d_v;
    logic        d_hs, d_vs, d_act, d_ls, d_fs;
    logic [7:0]  d_fc;
    logic [3:0]  s_h, s_v;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    logic [7:0]  s_fc;
    logic [10:0] w_h, w_v;
    logic        w_hs, w_vs, w_act, w_ls, w_fs;
    logic [7:0]  w_fc;

    int total = 0;
    int bad   = 0;

    vga_timing_gen u_def (
        .clk         (clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .h_count     (d_h),
        .v_count     (d_v),
        .h_sync      (d_hs),
        .v_sync      (d_vs),
        .active      (d_act),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .frame_cnt   (d_fc)
    );

    // 16 x 12 raster: 8/2/3/3 pixels, 6/1/2/3 lines
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (3),
        .CW       (4)
    ) u_small (
        .clk         (clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .h_count     (s_h),
        .v_count     (s_v),
        .h_sync      (s_hs),
        .v_sync      (s_vs),
        .active      (s_act),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_cnt   (s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (800), .H_FP (40), .H_SYNC (128), .H_BP (88),
        .V_ACTIVE (600), .V_FP (1),  .V_SYNC (4),   .V_BP (23),
        .H_POL    (1'b1), .V_POL (1'b1),
        .CW       (11)
    ) u_svga (
        .clk         (clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .h_count     (w_h),
        .v_count     (w_v),
        .h_sync      (w_hs),
        .v_sync      (w_vs),
        .active      (w_act),
        .line_start  (w_ls),
        .frame_start (w_fs),
        .frame_cnt   (w_fc)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int herr, lo, lf, ll, whi, wf, wl;
        int vlo, vf, vl, act, hlo, ferr, terr;
        logic [3:0] ph, pv;
        logic       phs, pvs;
        logic [9:0] pdh;

        Reset  = 1'b1;
        pix_en = 1'b0;
        step();
        step();
        chk("rst_h", d_h, 839);
        chk("rst_v", d_v, 499);
        chk("rst_fc", d_fc, 0);
        chk("rst_act", d_act, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_ls", d_ls, 0);
        chk("rst_fs", d_fs, 0);
        chk("rst_s_h", s_h, 15);
        chk("rst_s_v", s_v, 11);
        chk("rst_w_h", w_h, 1055);
        chk("rst_w_v", w_v, 627);
        chk("rst_w_hs", w_hs, 0);
        chk("rst_w_vs", w_vs, 0);

        Reset  = 1'b0;
        pix_en = 1'b1;
        step();
        chk("first_h", d_h, 0);
        chk("first_v", d_v, 0);
        chk("first_fs", d_fs, 1);
        chk("first_ls", d_ls, 1);
        chk("first_act", d_act, 1);
        chk("first_fc", d_fc, 0);
        chk("first_s_fs", s_fs, 1);

        herr = 0; lo = 0; lf = -1; ll = -1;
        whi = 0; wf = -1; wl = -1;
        for (int k = 1; k < 1056; k++) begin
            step();
            if (d_h != 10'(k % 840) || d_v != 10'(k / 840)) herr++;
            if (k < 840 && !d_hs) begin
                lo++;
                if (lf < 0) lf = k;
                ll = k;
            end
            if (w_hs) begin
                whi++;
                if (wf < 0) wf = k;
                wl = k;
            end
            if (k == 700) chk("hblank_act", d_act, 0);
            if (k == 840) begin
                chk("line2_v", d_v, 1);
                chk("line2_ls", d_ls, 1);
                chk("line2_fs", d_fs, 0);
            end
        end
        chk("hseq_err", herr, 0);
        chk("hs_low_cnt", lo, 64);
        chk("hs_low_first", lf, 656);
        chk("hs_low_last", ll, 719);
        chk("vs_idle", d_vs, 1);
        chk("w_hs_hi_cnt", whi, 128);
        chk("w_hs_first", wf, 840);
        chk("w_hs_last", wl, 967);
        chk("w_h_end", w_h, 1055);

        pix_en = 1'b0;
        repeat (3) step();
        chk("hold_h", d_h, 215);
        chk("hold_v", d_v, 1);
        chk("hold_w_h", w_h, 1055);

        Reset  = 1'b1;
        pix_en = 1'b1;
        step();
        Reset = 1'b0;
        step();
        vlo = 0; vf = -1; vl = -1; act = 0; hlo = 0;
        for (int k = 0; k < 192; k++) begin
            if (!s_vs) begin
                vlo++;
                if (vf < 0) vf = int'(s_v);
                vl = int'(s_v);
            end
            if (s_act) act++;
            if (!s_hs) hlo++;
            step();
        end
        chk("s_f2_fs", s_fs, 1);
        chk("s_f2_h", s_h, 0);
        chk("s_f2_v", s_v, 0);
        chk("s_f2_fc", s_fc, 1);
        chk("s_vs_low_cnt", vlo, 32);
        chk("s_vs_first", vf, 7);
        chk("s_vs_last", vl, 8);
        chk("s_act_cnt", act, 48);
        chk("s_hs_low_cnt", hlo, 36);

        ferr = 0;
        for (int f = 3; f <= 258; f++) begin
            repeat (192) step();
            if (!s_fs || s_fc != 8'((f - 1) % 256)) ferr++;
            if (f == 256) chk("fc_255", s_fc, 255);
            if (f == 257) chk("fc_wrap0", s_fc, 0);
            if (f == 258) chk("fc_258", s_fc, 1);
        end
        chk("frame_seq_err", ferr, 0);

        Reset  = 1'b1;
        pix_en = 1'b0;
        step();
        Reset  = 1'b0;
        pix_en = 1'b1;
        step();
        terr = 0;
        for (int i = 0; i < 384; i++) begin
            pix_en = (i % 2 == 1);
            ph  = s_h;
            pv  = s_v;
            phs = s_hs;
            pvs = s_vs;
            pdh = d_h;
            step();
            if (!pix_en && (s_h != ph || s_v != pv || s_hs != phs
                            || s_vs != pvs || d_h != pdh)) terr++;
        end
        chk("tog_hold_err", terr, 0);
        chk("tog_s_h", s_h, 0);
        chk("tog_s_v", s_v, 0);
        chk("tog_s_fs", s_fs, 1);
        chk("tog_s_fc", s_fc, 1);
        chk("tog_d_h", d_h, 192);

        pix_en = 1'b1;
        repeat (108) step();
        chk("mid_d_h", d_h, 300);
        chk("mid_d_v", d_v, 0);
        chk("mid_s_h", s_h, 12);
        chk("mid_s_v", s_v, 6);
        Reset = 1'b1;
        step();
        chk("mrst_d_h", d_h, 839);
        chk("mrst_d_v", d_v, 499);
        chk("mrst_act", d_act, 0);
        chk("mrst_hs", d_hs, 1);
        chk("mrst_s_h", s_h, 15);
        chk("mrst_s_v", s_v, 11);
        chk("mrst_s_fc", s_fc, 0);
        Reset  = 1'b0;
        pix_en = 1'b0;
        step();
        chk("mrel_hold", d_h, 839);
        pix_en = 1'b1;
        step();
        chk("mrel_h", d_h, 0);
        chk("mrel_v", d_v, 0);
        chk("mrel_fs", d_fs, 1);
        chk("mrel_fc", d_fc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 64, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 120, horizontal back porch in pixels; H_TOTAL = sum of H_* = 840.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 3, vertical sync width in lines.
REQ-008 Parameter V_BP, default 16, vertical back porch in lines; V_TOTAL = sum of V_* = 500.
REQ-009 Parameter H_POL / V_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-010 Parameter CW, default 10, counter width; SHALL satisfy 2^CW >= max(H_TOTAL, V_TOTAL).
REQ-011 clk  in  1  single clock; all state on rising edge.
REQ-012 Reset  in  1  synchronous, active-high reset.
REQ-013 pix_en  in  1  pixel strobe; counters advance only on clk edges where pix_en=1.
REQ-014 h_count  out  CW  current pixel column, 0..H_TOTAL-1.
REQ-015 v_count  out  CW  current line, 0..V_TOTAL-1.
REQ-016 h_sync / v_sync  out  1 each  sync pulses at polarity H_POL / V_POL.
REQ-017 active  out  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-018 line_start  out  1  high while h_count==0.
REQ-019 frame_start  out  1  high while h_count==0 and v_count==0.
REQ-020 frame_cnt  out  8  completed-frame counter, wraps 255->0.

Function
REQ-021 h_count, v_count, frame_cnt SHALL be registers; all other outputs SHALL be pure decodes of the current h_count/v_count (zero latency from counter value).
REQ-022 With pix_en=1: h_count increments by 1; at H_TOTAL-1 it wraps to 0 and v_count increments in the same edge.
REQ-023 At h_count=H_TOTAL-1 and v_count=V_TOTAL-1 with pix_en=1, both wrap to 0 and frame_cnt increments; the last line SHALL be fully scanned (no early wrap).
REQ-024 With pix_en=0, all registers SHALL hold; decoded outputs remain stable.
REQ-025 h_sync SHALL be asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else at ~H_POL.
REQ-026 v_sync SHALL be asserted for V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, else at ~V_POL; independent of h_count.
REQ-027 Counter compares SHALL be equality against TOTAL-1; counters never exceed TOTAL-1.
REQ-028 line_start/frame_start are one pixel period wide; consumers qualify with pix_en.

Reset
REQ-029 Reset=1 at an edge SHALL load h_count=H_TOTAL-1, v_count=V_TOTAL-1, frame_cnt=0, regardless of pix_en.
REQ-030 Consequently during reset: active=0, h_sync=~H_POL, v_sync=~V_POL, line_start=0, frame_start=0.
REQ-031 First pix_en=1 edge after Reset deasserts SHALL yield h_count=0, v_count=0, frame_start=1, frame_cnt=0 (no increment on this wrap).
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge; no partial state retained.

Structure
REQ-033 Shared package vga_timing_pkg SHALL hold default timing constants (640x480 set above) and CW.
REQ-034 One sub-module vga_axis_counter (parametrised TOTAL, CW; inputs en, load; outputs count, wrap) SHALL be instantiated twice, horizontal wrap feeding vertical enable.

Verification
REQ-035 Reset, then pix_en=1 constant -> h_count 0..839 repeating, v_count increments every 840 edges, frame period exactly 420000 edges.
REQ-036 Default params, pix_en=1 -> h_sync low for h_count 656..719 only (64 pixels); v_sync low for v_count 481..483 only.
REQ-037 pix_en toggling 1/0 each edge -> frame period 840000 edges; outputs unchanged on pix_en=0 edges.
REQ-038 Reset pulsed at h_count=300, v_count=200 -> next edge h_count=839, v_count=499, active=0; first enabled edge after release -> (0,0), frame_start=1.
REQ-039 H_POL=1, V_POL=1, 800x600 set (40/128/88, 1/4/23, CW=11) -> positive syncs, H_TOTAL=1056, V_TOTAL=628.
REQ-040 Run 257 frames -> frame_cnt wraps through 255->0 and reads 1 at start of the 258th frame.
